cavlc_coeff_scanner: RTL and testbench

CAVLC_COEFF_SCANNER -- requirements
Module: cavlc_coeff_scanner

---
 rtl/cavlc_pkg.sv | 16 +
 rtl/cavlc_t1_tracker.sv | 54 +++++
 rtl/cavlc_coeff_scanner.sv | 148 ++++++++++++++
 tb/tb_cavlc_coeff_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coefficient scanner.
// Lengths match the H.264 residual block kinds: luma 4x4, AC and chroma DC.
package cavlc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEF_MAX_COEFF = 16;
  localparam int LEN_LUMA      = 16;
  localparam int LEN_AC        = 15;
  localparam int LEN_CDC       = 4;

endpackage

// File: rtl/cavlc_t1_tracker.sv
// Counts trailing ones (|level|==1) from the first nonzero onwards and
// records their signs; freezes at three or at the first larger magnitude.
module cavlc_t1_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       nz_i,
  input  logic       is_one_i,
  input  logic       neg_i,
  output logic [1:0] t1_count_o,
  output logic [2:0] t1_sign_o
);

  logic [1:0] count_q, count_d;
  logic [2:0] sign_q, sign_d;
  logic       frozen_q, frozen_d;

  always_comb begin
    count_d  = count_q;
    sign_d   = sign_q;
    frozen_d = frozen_q;
    if (clr_i) begin
      count_d  = '0;
      sign_d   = '0;
      frozen_d = 1'b0;
    end else if (nz_i && !frozen_q) begin
      if (is_one_i) begin
        for (int i = 0; i < 3; i++) begin
          if (2'(i) == count_q) sign_d[i] = neg_i;
        end
        count_d = count_q + 2'd1;
        if (count_q == 2'd2) frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      sign_q   <= '0;
      frozen_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sign_q   <= sign_d;
      frozen_q <= frozen_d;
    end
  end

  assign t1_count_o = count_q;
  assign t1_sign_o  = sign_q;

endmodule

// File: rtl/cavlc_coeff_scanner.sv
// Scans one residual block in reverse zigzag order and produces the CAVLC
// syntax elements: total_coeff, trailing ones, total_zeros, run_before and levels.
module cavlc_coeff_scanner
  import cavlc_pkg::*;
#(
  parameter int  MAX_COEFF = DEF_MAX_COEFF,
  parameter int  COEFF_W   = 8,
  localparam int CW        = $clog2(MAX_COEFF + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                blk_start_i,
  input  logic [CW-1:0]                       blk_len_i,
  input  logic                                coeff_valid_i,
  input  logic [COEFF_W-1:0]                  coeff_i,
  output logic                                coeff_ready_o,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [CW-1:0]                       total_coeff_o,
  output logic [1:0]                          trailing_ones_o,
  output logic [2:0]                          t1_sign_o,
  output logic [CW-1:0]                       total_zeros_o,
  output logic [MAX_COEFF-1:0][CW-1:0]        runbefore_list_o,
  output logic [MAX_COEFF-1:0][COEFF_W-1:0]   level_list_o,
  output logic                                busy_o
);

  state_e             state_q, state_d;
  logic [CW-1:0]      len_q, len_d;
  logic [CW-1:0]      pos_q, pos_d;
  logic [CW-1:0]      tc_q, tc_d;
  logic [CW-1:0]      tz_q, tz_d;
  logic [CW-1:0]      run_q, run_d;
  logic [COEFF_W-1:0] level_q [MAX_COEFF];
  logic [COEFF_W-1:0] level_d [MAX_COEFF];
  logic [CW-1:0]      rb_q    [MAX_COEFF];
  logic [CW-1:0]      rb_d    [MAX_COEFF];
  logic               clr;
  logic               nz;
  logic               is_one;

  // Magnitude one means +1 or the all-ones two's complement pattern (-1).
  assign is_one = (coeff_i == COEFF_W'(1)) || (coeff_i == {COEFF_W{1'b1}});

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    tc_d    = tc_q;
    tz_d    = tz_q;
    run_d   = run_q;
    level_d = level_q;
    rb_d    = rb_q;
    clr     = 1'b0;
    nz      = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_start_i) begin
          state_d = SCAN;
          len_d   = ((blk_len_i == '0) || (blk_len_i > CW'(MAX_COEFF))) ? CW'(MAX_COEFF) : blk_len_i;
          pos_d   = '0;
          tc_d    = '0;
          tz_d    = '0;
          run_d   = '0;
          level_d = '{default: '0};
          rb_d    = '{default: '0};
          clr     = 1'b1;
        end
      end
      SCAN: begin
        if (coeff_valid_i) begin
          pos_d = pos_q + CW'(1);
          if (coeff_i != '0) begin
            nz    = 1'b1;
            tc_d  = tc_q + CW'(1);
            run_d = '0;
            for (int i = 0; i < MAX_COEFF; i++) begin
              if (CW'(i) == tc_q) level_d[i] = coeff_i;
              if ((tc_q != '0) && (CW'(i) == tc_q - CW'(1))) rb_d[i] = run_q;
            end
          end else if (tc_q != '0) begin
            // Zeros only count once the first (highest-frequency) nonzero is seen.
            run_d = run_q + CW'(1);
            tz_d  = tz_q + CW'(1);
          end
          if (pos_q == len_q - CW'(1)) begin
            state_d = HOLD;
            for (int i = 0; i < MAX_COEFF; i++) begin
              if ((tc_d != '0) && (CW'(i) == tc_d - CW'(1))) rb_d[i] = run_d;
            end
          end
        end
      end
      HOLD: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      pos_q   <= '0;
      tc_q    <= '0;
      tz_q    <= '0;
      run_q   <= '0;
      level_q <= '{default: '0};
      rb_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      tc_q    <= tc_d;
      tz_q    <= tz_d;
      run_q   <= run_d;
      level_q <= level_d;
      rb_q    <= rb_d;
    end
  end

  cavlc_t1_tracker u_t1 (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .nz_i       (nz),
    .is_one_i   (is_one),
    .neg_i      (coeff_i[COEFF_W-1]),
    .t1_count_o (trailing_ones_o),
    .t1_sign_o  (t1_sign_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < MAX_COEFF; gi++) begin : g_lists
      assign level_list_o[gi]     = level_q[gi];
      assign runbefore_list_o[gi] = rb_q[gi];
    end
  endgenerate

  assign coeff_ready_o = (state_q == SCAN);
  assign res_valid_o   = (state_q == HOLD);
  assign busy_o        = (state_q != IDLE);
  assign total_coeff_o = tc_q;
  assign total_zeros_o = tz_q;

endmodule

// File: tb/tb_cavlc_coeff_scanner.sv
// Directed bench for cavlc_coeff_scanner with hand-computed expected results.
module tb_cavlc_coeff_scanner;
  import cavlc_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             blk_start;
  logic [4:0]       blk_len;
  logic             coeff_valid;
  logic [7:0]       coeff;
  logic             coeff_ready;
  logic             res_valid;
  logic             res_ready;
  logic [4:0]       total_coeff;
  logic [1:0]       trailing_ones;
  logic [2:0]       t1_sign;
  logic [4:0]       total_zeros;
  logic [15:0][4:0] rb_list;
  logic [15:0][7:0] lv_list;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] stim   [16];
  logic [7:0] exp_lv [16];
  logic [4:0] exp_rb [16];

  always #5 clk = ~clk;

  cavlc_coeff_scanner dut (
    .clk              (clk),
    .rst              (rst),
    .blk_start_i      (blk_start),
    .blk_len_i        (blk_len),
    .coeff_valid_i    (coeff_valid),
    .coeff_i          (coeff),
    .coeff_ready_o    (coeff_ready),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .total_coeff_o    (total_coeff),
    .trailing_ones_o  (trailing_ones),
    .t1_sign_o        (t1_sign),
    .total_zeros_o    (total_zeros),
    .runbefore_list_o (rb_list),
    .level_list_o     (lv_list),
    .busy_o           (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_result(input string name, input logic [4:0] tc, input logic [1:0] t1,
                              input logic [2:0] sgn, input logic [4:0] tz);
    check({name, ".total_coeff"}, 32'(total_coeff), 32'(tc));
    check({name, ".trailing_ones"}, 32'(trailing_ones), 32'(t1));
    check({name, ".t1_sign"}, 32'(t1_sign), 32'(sgn));
    check({name, ".total_zeros"}, 32'(total_zeros), 32'(tz));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s.level[%0d]", name, i), 32'(lv_list[i]), 32'(exp_lv[i]));
      check($sformatf("%s.run[%0d]", name, i), 32'(rb_list[i]), 32'(exp_rb[i]));
    end
  endtask

  task automatic clear_expect();
    exp_lv = '{default: 8'h00};
    exp_rb = '{default: 5'd0};
  endtask

  task automatic start_block(input logic [4:0] len);
    @(negedge clk);
    blk_start = 1'b1;
    blk_len   = len;
    @(negedge clk);
    blk_start = 1'b0;
  endtask

  // Presents stim[0..n-1], one per cycle, with an optional one-cycle valid gap.
  task automatic feed(input int n, input int gap_at, input bit done);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        coeff_valid = 1'b0;
        @(negedge clk);
      end
      coeff_valid = 1'b1;
      coeff       = stim[i];
      check($sformatf("coeff_ready@%0d", i), 32'(coeff_ready), 32'd1);
      check($sformatf("res_valid_early@%0d", i), 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    coeff_valid = 1'b0;
    coeff       = 8'h00;
    if (done) begin
      check("res_valid_after_last", 32'(res_valid), 32'd1);
      check("coeff_ready_in_hold", 32'(coeff_ready), 32'd0);
      check("busy_in_hold", 32'(busy), 32'd1);
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("busy_after_release", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; blk_start = 1'b0; blk_len = '0;
    coeff_valid = 1'b0; coeff = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    clear_expect();
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.coeff_ready", 32'(coeff_ready), 32'd0);
    check("reset.res_valid", 32'(res_valid), 32'd0);
    check_result("reset", 5'd0, 2'd0, 3'b000, 5'd0);
    $display("vector reset: busy=%0d tc=%0d", busy, total_coeff);

    // Mixed block with a valid gap: 7 zeros,1,0,1,-1,0,0,-1,3,0
    stim = '{default: 8'h00};
    stim[7] = 8'h01; stim[9] = 8'h01; stim[10] = 8'hFF; stim[13] = 8'hFF; stim[14] = 8'h03;
    start_block(5'(LEN_LUMA));
    feed(16, 3, 1'b1);
    clear_expect();
    exp_lv[0] = 8'h01; exp_lv[1] = 8'h01; exp_lv[2] = 8'hFF; exp_lv[3] = 8'hFF; exp_lv[4] = 8'h03;
    exp_rb[0] = 5'd1; exp_rb[1] = 5'd0; exp_rb[2] = 5'd2; exp_rb[3] = 5'd0; exp_rb[4] = 5'd1;
    check_result("mixed16", 5'd5, 2'd3, 3'b100, 5'd4);
    $display("vector mixed16: tc=%0d t1=%0d sign=%b tz=%0d", total_coeff, trailing_ones, t1_sign, total_zeros);
    release_result();

    // All-zero luma block
    stim = '{default: 8'h00};
    start_block(5'd16);
    feed(16, -1, 1'b1);
    clear_expect();
    check_result("zero16", 5'd0, 2'd0, 3'b000, 5'd0);
    $display("vector zero16: tc=%0d t1=%0d tz=%0d", total_coeff, trailing_ones, total_zeros);
    release_result();

    // Chroma DC block: -2,0,0,5
    stim = '{default: 8'h00};
    stim[0] = 8'hFE; stim[3] = 8'h05;
    start_block(5'(LEN_CDC));
    feed(4, -1, 1'b1);
    clear_expect();
    exp_lv[0] = 8'hFE; exp_lv[1] = 8'h05; exp_rb[0] = 5'd2; exp_rb[1] = 5'd0;
    check_result("cdc4", 5'd2, 2'd0, 3'b000, 5'd2);
    $display("vector cdc4: tc=%0d t1=%0d tz=%0d", total_coeff, trailing_ones, total_zeros);
    release_result();

    // Zero length clamps to 16; T1 freezes at the first |level|>1
    stim = '{default: 8'h00};
    stim[12] = 8'hFF; stim[13] = 8'h02; stim[15] = 8'hFF;
    start_block(5'd0);
    feed(16, -1, 1'b1);
    clear_expect();
    exp_lv[0] = 8'hFF; exp_lv[1] = 8'h02; exp_lv[2] = 8'hFF;
    exp_rb[0] = 5'd0; exp_rb[1] = 5'd1; exp_rb[2] = 5'd0;
    check_result("clamp0", 5'd3, 2'd1, 3'b001, 5'd1);
    $display("vector clamp0: tc=%0d t1=%0d sign=%b tz=%0d", total_coeff, trailing_ones, t1_sign, total_zeros);
    release_result();

    // Full alternating block, then a long HOLD with ignored inputs
    for (int i = 0; i < 16; i++) begin
      stim[i] = (i % 2 == 0) ? 8'h01 : 8'hFF;
      exp_lv[i] = stim[i];
    end
    exp_rb = '{default: 5'd0};
    start_block(5'd16);
    feed(16, -1, 1'b1);
    check_result("alt16", 5'd16, 2'd3, 3'b010, 5'd0);
    $display("vector alt16: tc=%0d t1=%0d sign=%b tz=%0d", total_coeff, trailing_ones, t1_sign, total_zeros);
    for (int c = 0; c < 5; c++) begin
      blk_start   = (c == 2);
      blk_len     = 5'd4;
      coeff_valid = 1'b1;
      coeff       = 8'h07;
      @(negedge clk);
      check($sformatf("hold.res_valid@%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("hold.coeff_ready@%0d", c), 32'(coeff_ready), 32'd0);
      check($sformatf("hold.tc@%0d", c), 32'(total_coeff), 32'd16);
      check($sformatf("hold.sign@%0d", c), 32'(t1_sign), 32'b010);
      check($sformatf("hold.level1@%0d", c), 32'(lv_list[1]), 32'hFF);
    end
    blk_start = 1'b0; coeff_valid = 1'b0; coeff = 8'h00;
    release_result();
    check("idle.res_valid", 32'(res_valid), 32'd0);
    check("idle.retained_tc", 32'(total_coeff), 32'd16);
    check("idle.retained_t1", 32'(trailing_ones), 32'd3);
    $display("vector hold: busy=%0d tc=%0d", busy, total_coeff);

    // Reset after 7 accepts abandons the block
    for (int i = 0; i < 16; i++) stim[i] = 8'h02;
    start_block(5'd16);
    feed(7, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_expect();
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.coeff_ready", 32'(coeff_ready), 32'd0);
    check("midrst.res_valid", 32'(res_valid), 32'd0);
    check_result("midrst", 5'd0, 2'd0, 3'b000, 5'd0);
    $display("vector midrst: busy=%0d tc=%0d", busy, total_coeff);

    stim = '{default: 8'h00};
    stim[0] = 8'hFE; stim[3] = 8'h05;
    start_block(5'd4);
    feed(4, -1, 1'b1);
    clear_expect();
    exp_lv[0] = 8'hFE; exp_lv[1] = 8'h05; exp_rb[0] = 5'd2; exp_rb[1] = 5'd0;
    check_result("cdc4_after_rst", 5'd2, 2'd0, 3'b000, 5'd2);
    $display("vector cdc4_after_rst: tc=%0d t1=%0d tz=%0d", total_coeff, trailing_ones, total_zeros);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
